// File: rtl/usb_tx_arb_pkg.sv
// Shared types and widths for the USB upstream packet arbiter and its round-robin picker.
// Holds no logic: constants, the FSM encoding and a width helper only.
package usb_tx_arb_pkg;

   localparam int WORD_W  = 16;
   localparam int GRANT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BODY = 2'd2
   } state_t;

   // Enough bits to hold every body count from 0 up to max_words.
   function automatic int remain_w(input int max_words);
      return $clog2(max_words + 1);
   endfunction

endpackage

// File: rtl/usb_tx_packet_arbiter_rr_pick.sv
// Round-robin selector: first requester after i_last, wrapping modulo N_SRC.
// Purely combinational, zero latency; the owner decides when a pick is committed.
module rr_pick
   import usb_tx_arb_pkg::*;
#(
   parameter int N_SRC = 2
) (
   input  logic [N_SRC-1:0]   i_req,
   input  logic [GRANT_W-1:0] i_last,
   output logic [GRANT_W-1:0] o_idx,
   output logic               o_valid
);

   localparam int SLOTS = 1 << GRANT_W;

   logic [SLOTS-1:0] w_req;

   for (genvar g = 0; g < SLOTS; g++) begin : g_req
      if (g < N_SRC) begin : g_live
         assign w_req[g] = i_req[g];
      end else begin : g_unused
         assign w_req[g] = 1'b0;
      end
   end

   function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] base,
                                                   input int step);
      int s;
      s = int'(base) + step;
      if (s >= N_SRC) s = s - N_SRC;
      return s[GRANT_W-1:0];
   endfunction

   // Walk from the farthest candidate to the nearest so the nearest one wins.
   always_comb begin
      o_idx   = i_last;
      o_valid = 1'b0;
      for (int k = N_SRC; k >= 1; k--) begin
         if (w_req[wrap_inc(i_last, k)]) begin
            o_idx   = wrap_inc(i_last, k);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_tx_packet_arbiter.sv
// Packet-granular round-robin arbiter onto one FWFT upstream port; grant one cycle after ready in IDLE.
// Data path is combinational (pop follows i_tx_rd_en same cycle); stalled packets are aborted by a watchdog.
module usb_tx_packet_arbiter
   import usb_tx_arb_pkg::*;
#(
   parameter int N_SRC     = 2,
   parameter int MAX_WORDS = 1024,
   parameter int TIMEOUT   = 4096
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_en,
   input  logic [N_SRC-1:0]        i_src_pkt_ready,
   input  logic [N_SRC-1:0]        i_src_empty,
   input  logic [WORD_W*N_SRC-1:0] i_src_data,
   output logic [N_SRC-1:0]        o_src_rd_en,
   output logic [WORD_W-1:0]       o_tx_data,
   output logic                    o_tx_empty,
   input  logic                    i_tx_rd_en,
   output logic [GRANT_W-1:0]      o_grant,
   output logic                    o_busy,
   output logic                    o_len_err,
   output logic                    o_timeout_err,
   output logic [15:0]             o_pkt_count
);

   localparam int SLOTS = 1 << GRANT_W;
   localparam int REM_W = remain_w(MAX_WORDS);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   localparam logic [REM_W-1:0]  MAX_REM   = REM_W'(MAX_WORDS);
   localparam logic [WORD_W-1:0] MAX_LEN   = WORD_W'(MAX_WORDS);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(N_SRC - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [GRANT_W-1:0]  r_grant;
   logic [GRANT_W-1:0]  r_last;
   logic [REM_W-1:0]    r_remain;
   logic [WD_W-1:0]     r_wd;
   logic                r_len_err;
   logic                r_timeout_err;
   logic [15:0]         r_pkt_count;

   logic [WORD_W-1:0]   w_words [SLOTS];
   logic [SLOTS-1:0]    w_empty;
   logic [WORD_W-1:0]   w_head;
   logic                w_src_empty;
   logic                w_active;
   logic                w_pop;
   logic                w_over;
   logic [REM_W-1:0]    w_load_val;
   logic                w_abort;
   logic [GRANT_W-1:0]  w_pick_idx;
   logic                w_pick_vld;
   logic                w_grant_go;
   logic                w_hdr_load;
   logic                w_complete;

   // Pad the source vectors to the full grant index range so selection by r_grant is width-exact.
   for (genvar g = 0; g < SLOTS; g++) begin : g_src
      if (g < N_SRC) begin : g_live
         assign w_words[g] = i_src_data[WORD_W*g +: WORD_W];
         assign w_empty[g] = i_src_empty[g];
      end else begin : g_unused
         assign w_words[g] = '0;
         assign w_empty[g] = 1'b1;
      end
   end

   rr_pick #(
      .N_SRC   (N_SRC)
   ) u_rr_pick (
      .i_req   (i_src_pkt_ready),
      .i_last  (r_last),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_vld)
   );

   assign w_head      = w_words[r_grant];
   assign w_src_empty = w_empty[r_grant];
   assign w_active    = (r_state == ST_HDR) || (r_state == ST_BODY);
   assign o_tx_empty  = !w_active || w_src_empty;
   assign o_tx_data   = w_head;
   assign w_pop       = i_tx_rd_en && !o_tx_empty;
   assign w_over      = w_head > MAX_LEN;
   assign w_load_val  = w_over ? MAX_REM : REM_W'(w_head);
   // Any pop needs a non-empty source, which also clears the watchdog, so abort and completion never coincide.
   assign w_abort     = w_active && w_src_empty && (r_wd == WD_LAST);

   always_comb begin
      o_src_rd_en = '0;
      for (int i = 0; i < N_SRC; i++) begin
         o_src_rd_en[i] = w_pop && (r_grant == GRANT_W'(i));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_go  = 1'b0;
      w_hdr_load  = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_en && w_pick_vld) begin
               w_grant_go  = 1'b1;
               w_state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            if (w_abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_pop) begin
               w_hdr_load = 1'b1;
               if (w_load_val == '0) begin
                  w_complete  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_BODY;
               end
            end
         end
         ST_BODY: begin
            if (w_abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_pop && (r_remain == REM_W'(1))) begin
               w_complete  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_grant       <= '0;
         r_last        <= LAST_RST;
         r_remain      <= '0;
         r_wd          <= '0;
         r_len_err     <= 1'b0;
         r_timeout_err <= 1'b0;
         r_pkt_count   <= '0;
      end else begin
         if (w_grant_go) r_grant <= w_pick_idx;

         if (w_hdr_load) begin
            r_remain <= w_load_val;
         end else if ((r_state == ST_BODY) && w_pop) begin
            r_remain <= r_remain - REM_W'(1);
         end

         if (!w_active || !w_src_empty || w_abort) begin
            r_wd <= '0;
         end else begin
            r_wd <= r_wd + WD_W'(1);
         end

         if (w_hdr_load && w_over) r_len_err <= 1'b1;
         if (w_abort) r_timeout_err <= 1'b1;
         // An aborted source also drops to lowest priority.
         if (w_complete || w_abort) r_last <= r_grant;
         if (w_complete) r_pkt_count <= r_pkt_count + 16'd1;
      end
   end

   assign o_grant       = r_grant;
   assign o_busy        = w_active;
   assign o_len_err     = r_len_err;
   assign o_timeout_err = r_timeout_err;
   assign o_pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_usb_tx_packet_arbiter.sv
// Bench for usb_tx_packet_arbiter: queue-backed FWFT sources, packet-level reference model, directed scenarios.
module tb_usb_tx_packet_arbiter;

   localparam int N    = 2;
   localparam int MAXW = 4;
   localparam int TO   = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic            tx_rd_en;
   logic [N-1:0]    pkt_ready;
   logic [N-1:0]    src_empty;
   logic [16*N-1:0] src_data;
   logic [N-1:0]    src_rd_en;
   logic [15:0]     tx_data;
   logic            tx_empty;
   logic [1:0]      grant;
   logic            busy;
   logic            len_err;
   logic            timeout_err;
   logic [15:0]     pkt_count;

   always #5 clk = ~clk;

   usb_tx_packet_arbiter #(
      .N_SRC     (N),
      .MAX_WORDS (MAXW),
      .TIMEOUT   (TO)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_en            (en),
      .i_src_pkt_ready (pkt_ready),
      .i_src_empty     (src_empty),
      .i_src_data      (src_data),
      .o_src_rd_en     (src_rd_en),
      .o_tx_data       (tx_data),
      .o_tx_empty      (tx_empty),
      .i_tx_rd_en      (tx_rd_en),
      .o_grant         (grant),
      .o_busy          (busy),
      .o_len_err       (len_err),
      .o_timeout_err   (timeout_err),
      .o_pkt_count     (pkt_count)
   );

   logic [15:0] q [N][$];
   logic [15:0] txlog[$];
   logic [15:0] expq[$];
   int          glog[$];
   int          pop_cyc[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc_n = 0;
   int          rd0 = 0;
   bit          prev_busy = 0;

   // Reference model: packet in flight, words still owed, priority pointer, counters.
   bit m_busy, m_hdr, m_len, m_to;
   int m_src, m_last, m_left, m_stall, m_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc_n);
   endtask

   task automatic model_reset();
      m_busy = 0; m_hdr = 0; m_len = 0; m_to = 0;
      m_src = 0; m_last = N - 1; m_left = 0; m_stall = 0; m_cnt = 0;
   endtask

   task automatic drive_src();
      for (int i = 0; i < N; i++) begin
         src_empty[i] = (q[i].size() == 0);
         pkt_ready[i] = (q[i].size() != 0);
         src_data[16*i +: 16] = (q[i].size() == 0) ? 16'h0 : q[i][0];
      end
   endtask

   task automatic compare();
      bit          e_empty;
      logic [N-1:0] e_rd;
      e_empty = !m_busy || (q[m_src].size() == 0);
      e_rd = '0;
      if (!e_empty && tx_rd_en) e_rd[m_src] = 1'b1;
      chk("busy", busy, m_busy);
      chk("grant", grant, m_src);
      chk("tx_empty", tx_empty, e_empty);
      if (!e_empty) chk("tx_data", tx_data, q[m_src][0]);
      chk("src_rd_en", src_rd_en, e_rd);
      chk("len_err", len_err, m_len);
      chk("timeout_err", timeout_err, m_to);
      chk("pkt_count", pkt_count, m_cnt);
   endtask

   task automatic model_step();
      int s;
      int w;
      if (!m_busy) begin
         if (en && (pkt_ready != '0)) begin
            s = 0;
            for (int k = N; k >= 1; k--) if (pkt_ready[(m_last + k) % N]) s = (m_last + k) % N;
            m_src = s; m_busy = 1; m_hdr = 1; m_stall = 0;
         end
      end else if (q[m_src].size() == 0) begin
         m_stall++;
         if (m_stall == TO) begin
            m_to = 1; m_busy = 0; m_last = m_src; m_stall = 0;
         end
      end else begin
         m_stall = 0;
         if (tx_rd_en) begin
            if (m_hdr) begin
               w = int'(q[m_src][0]);
               m_hdr = 0;
               if (w > MAXW) begin m_len = 1; m_left = MAXW; end
               else m_left = w;
            end else begin
               m_left--;
            end
            if (m_left == 0) begin
               m_busy = 0; m_last = m_src; m_cnt = (m_cnt + 1) % 65536;
            end
         end
      end
   endtask

   task automatic cyc();
      logic [N-1:0] pend;
      @(negedge clk);
      cyc_n++;
      if (rst_n) begin
         compare();
         if (tx_rd_en && !tx_empty) begin
            txlog.push_back(tx_data);
            pop_cyc.push_back(cyc_n);
         end
         if (src_rd_en[0]) rd0++;
         if (busy && !prev_busy) glog.push_back(int'(grant));
         prev_busy = busy;
         model_step();
      end else begin
         prev_busy = 0;
      end
      pend = src_rd_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (pend[i] && q[i].size() > 0) void'(q[i].pop_front());
      drive_src();
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      cyc();
      cyc();
      rst_n = 1;
   endtask

   task automatic run_until_idle(input string nm, input int budget);
      int n;
      n = 0;
      while ((busy || q[0].size() > 0 || q[1].size() > 0) && n < budget) begin
         cyc();
         n++;
      end
      chk({nm, " drained in budget"}, (n < budget), 1);
   endtask

   task automatic wait_busy(input string nm, input int budget);
      int n;
      n = 0;
      while (!busy && n < budget) begin
         cyc();
         n++;
      end
      chk({nm, " grant in budget"}, busy, 1);
   endtask

   task automatic cmp_log(input string nm);
      chk({nm, " length"}, txlog.size(), expq.size());
      for (int i = 0; i < expq.size() && i < txlog.size(); i++) chk(nm, txlog[i], expq[i]);
   endtask

   initial begin
      #1000000;
      $display("FAIL global time limit reached");
      $fatal(1);
   end

   initial begin
      int stall;
      int n;
      int bc;
      bit seen;
      rst_n = 0; en = 0; tx_rd_en = 0;
      model_reset();
      drive_src();
      do_reset();

      chk("rst busy", busy, 0);
      chk("rst tx_empty", tx_empty, 1);
      chk("rst grant", grant, 0);
      chk("rst src_rd_en", src_rd_en, 0);
      chk("rst pkt_count", pkt_count, 0);
      chk("rst flags", {len_err, timeout_err}, 0);

      // Fairness: both sources keep two packets queued.
      en = 1; tx_rd_en = 1;
      q[0] = {16'd1, 16'hA000, 16'd1, 16'hA001};
      q[1] = {16'd2, 16'hB000, 16'hB001, 16'd0};
      txlog.delete(); glog.delete();
      drive_src();
      run_until_idle("fair", 100);
      chk("fair grant count", glog.size(), 4);
      for (int i = 0; i < 4 && i < glog.size(); i++) chk("fair grant order", glog[i], i % 2);
      expq = {16'd1, 16'hA000, 16'd2, 16'hB000, 16'hB001, 16'd1, 16'hA001, 16'd0};
      cmp_log("fair stream");
      chk("fair pkt_count", pkt_count, 4);

      // Single source, continuous pops.
      do_reset();
      txlog.delete(); pop_cyc.delete(); rd0 = 0;
      q[0] = {16'd3, 16'h1A1A, 16'h2B2B, 16'h3C3C};
      drive_src();
      run_until_idle("single", 50);
      expq = {16'd3, 16'h1A1A, 16'h2B2B, 16'h3C3C};
      cmp_log("single stream");
      chk("single rd_en0 cycles", rd0, 4);
      if (pop_cyc.size() == 4) chk("single consecutive", pop_cyc[3] - pop_cyc[0], 3);
      chk("single pkt_count", pkt_count, 1);
      chk("single busy after", busy, 0);

      // Length clamp: 9 requested, 4 allowed.
      txlog.delete();
      q[1] = {16'd9, 16'hC000, 16'hC001, 16'hC002, 16'hC003};
      drive_src();
      run_until_idle("clamp", 50);
      expq = {16'd9, 16'hC000, 16'hC001, 16'hC002, 16'hC003};
      cmp_log("clamp stream");
      chk("clamp len_err", len_err, 1);
      chk("clamp pkt_count", pkt_count, 2);

      // Stall: source 0 runs dry after header + 1 body word.
      q[0] = {16'd4, 16'hD000};
      q[1] = {16'd0};
      drive_src();
      stall = 0; n = 0;
      while (!timeout_err && n < 100) begin
         cyc();
         n++;
         if (busy && grant == 2'd0 && src_empty[0]) stall++;
      end
      chk("stall cycles", stall, TO);
      chk("stall timeout_err", timeout_err, 1);
      chk("stall pkt_count", pkt_count, 2);
      chk("stall busy", busy, 0);
      wait_busy("regrant", 10);
      chk("regrant source", grant, 1);
      run_until_idle("regrant", 20);
      chk("regrant pkt_count", pkt_count, 3);

      // Gating and zero-length packets.
      en = 0;
      q[0] = {16'd0};
      q[1] = {16'd1, 16'h5555};
      drive_src();
      seen = 0;
      for (int i = 0; i < 8; i++) begin cyc(); if (busy) seen = 1; end
      chk("gated busy", seen, 0);
      en = 1;
      wait_busy("zero-len", 10);
      en = 0;
      chk("zero-len grant", grant, 0);
      bc = 0; n = 0;
      while (busy && n < 10) begin bc++; cyc(); n++; end
      chk("zero-len busy cycles", bc, 1);
      chk("zero-len pkt_count", pkt_count, 4);
      seen = 0;
      for (int i = 0; i < 5; i++) begin cyc(); if (busy) seen = 1; end
      chk("gated again busy", seen, 0);
      en = 1;
      wait_busy("en drop", 10);
      chk("en drop grant", grant, 1);
      en = 0;
      run_until_idle("en drop", 20);
      chk("en drop pkt_count", pkt_count, 5);

      // Asynchronous reset in the middle of a body.
      en = 1;
      q[0] = {16'd3, 16'hE000, 16'hE001, 16'hE002};
      drive_src();
      wait_busy("areset", 10);
      cyc();
      #2;
      rst_n = 0;
      #1;
      chk("areset tx_empty", tx_empty, 1);
      chk("areset src_rd_en", src_rd_en, 0);
      chk("areset busy", busy, 0);
      chk("areset flags", {len_err, timeout_err}, 0);
      chk("areset pkt_count", pkt_count, 0);
      chk("areset grant", grant, 0);
      model_reset();
      q[0].delete(); q[1].delete();
      drive_src();
      cyc();
      cyc();
      rst_n = 1;
      q[1] = {16'd0};
      drive_src();
      run_until_idle("recover", 20);
      chk("recover pkt_count", pkt_count, 1);
      chk("recover grant", grant, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/usb_tx_packet_arbiter.md
# usb_tx_packet_arbiter

Packet-granular round-robin arbiter sharing the single USB upstream path (the FWFT data/empty/rd_en interface read by the slave-FIFO engine on the EP8 side) between up to four packet sources, e.g. event data and register readback. Whole packets are granted at a time, so a packet from one source is never interleaved with words from another. Each packet starts with a length word. The block enforces a maximum length and aborts stalled packets with a watchdog.

## Interface
Parameters:
- `N_SRC`, 2: number of requesting sources, legal range 1–4.
- `MAX_WORDS`, 1024: maximum body length in words; must be at most 65535.
- `TIMEOUT`, 4096: number of consecutive mid-packet cycles with the granted source empty before the packet is aborted.

Ports:
- `clk`  in  1  USB FIFO clock (locked IFCLK domain). Single clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `en`  in  1  Grant enable. When low, no new grants are issued; a packet already in flight completes.
- `src_pkt_ready`  in  N_SRC  Per-source flag: at least one complete packet is buffered.
- `src_empty`  in  N_SRC  Per-source FWFT empty flag.
- `src_data`  in  16*N_SRC  Per-source FWFT head word. Source i occupies bits [16i+15:16i].
- `src_rd_en`  out  N_SRC  Per-source pop strobe.
- `tx_data`  out  16  Word presented to the USB engine.
- `tx_empty`  out  1  Low when `tx_data` is valid.
- `tx_rd_en`  in  1  USB engine pop strobe.
- `grant`  out  2  Index of the source currently or most recently granted.
- `busy`  out  1  High while a packet is in flight.
- `len_err`  out  1  Sticky flag: a length word exceeded MAX_WORDS.
- `timeout_err`  out  1  Sticky flag: a packet was aborted by the watchdog.
- `pkt_count`  out  16  Count of completed packets, wraps modulo 2^16.

## Operation
Packet format:
- Word 0 is the length L, the number of body words that follow.
- L = 0 is legal and denotes a header-only packet.

States: IDLE, HDR, BODY.
- **IDLE:** If `en` is high and any `src_pkt_ready` bit is set, select a source round-robin, starting the search at `last+1` modulo N_SRC. Register the selection into `grant` and go to HDR.
- **HDR:** Forward the granted source's head word. On a pop (`tx_rd_en & !tx_empty`):
  - Load `remain = min(word, MAX_WORDS)`.
  - If word > MAX_WORDS, set `len_err`; the packet is truncated to MAX_WORDS body words.
  - If `remain` = 0, the packet completes; otherwise go to BODY.
- **BODY:** Each pop decrements `remain`. The pop with `remain` = 1 completes the packet.
- **Completion:** Set `last = grant`, increment `pkt_count`, return to IDLE.

Datapath (combinational):
- `tx_data = src_data[grant]`.
- `tx_empty = !(state ∈ {HDR, BODY}) | src_empty[grant]`.
- `src_rd_en[i] = (i == grant) & tx_rd_en & !tx_empty`. Only the granted source is ever popped.
- `tx_rd_en` while `tx_empty` is high is ignored.

Watchdog:
- In HDR or BODY, a counter increments on each cycle where `src_empty[grant]` is high, and clears on any cycle where it is low.
- When the counter reaches TIMEOUT: set `timeout_err`, go to IDLE, and leave `pkt_count` unchanged.
- `last` is still updated, so the stalled source loses priority.
- Any unread words of the aborted packet remain in the source and are not flushed.

Other rules:
- `busy` is high in HDR and BODY.
- Dropping `en` mid-packet has no effect on the packet in flight.
- `src_pkt_ready` is sampled only in IDLE.

## Timing
- Reset values:
  - state = IDLE, `grant` = 0, `last` = N_SRC−1 (so source 0 has first priority).
  - `tx_empty` = 1, `src_rd_en` = 0.
  - `busy`, `len_err`, `timeout_err` = 0; `pkt_count` = 0; `remain` = 0; watchdog = 0.
- Grant latency: `src_pkt_ready` high in IDLE at edge k gives state HDR after edge k. `tx_empty` falls in the same cycle if the source is non-empty.
- Throughput: one word per cycle while `tx_rd_en` is held high.
- Packet gap: one IDLE cycle between back-to-back packets.
- An (L+1)-word packet occupies L+2 cycles including the IDLE cycle.
- `src_rd_en` and `tx_data` follow `tx_rd_en` in the same cycle, with no added pipeline.
- Sticky flags clear only on reset.
- Reset asserted mid-packet returns the block to IDLE immediately; the partially transferred source is not flushed.
- Completion and abort in the same cycle (final pop coincides with the watchdog reaching TIMEOUT) cannot occur, because a pop requires the source to be non-empty, which clears the watchdog.

## Structure
- Package `usb_tx_arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_HDR`, `ST_BODY`);
  - `WORD_W` = 16;
  - the width of `remain` (`$clog2(MAX_WORDS+1)`);
  - the `grant` width.
- One sub-module, `rr_pick`: purely combinational round-robin selector with inputs `req[N_SRC]` and `last`, and outputs `idx` and `valid`. Reusable by other shared resources.

## Test plan
- Single source: source 0 holds packet [3, A, B, C] and the engine pops continuously. Required: `tx_data` sequence 3, A, B, C on consecutive cycles; `src_rd_en[0]` high for 4 cycles; `pkt_count` = 1; `busy` low afterwards.
- Fairness: both sources hold ready packets continuously. Required: grants alternate 0, 1, 0, 1, … with source 0 first after reset; no interleaving within any packet.
- Length clamp: MAX_WORDS = 4 and source 1 sends length 9. Required: exactly 4 body words are forwarded, `len_err` = 1, `pkt_count` increments by 1.
- Stall and timeout: TIMEOUT = 16; source 0 empties after the header plus 1 body word of a 5-word packet. Required: after 16 cycles the block returns to IDLE with `timeout_err` = 1 and `pkt_count` unchanged; the next grant goes to source 1.
- Zero-length and gating: a header-only packet (L = 0) completes in the HDR pop cycle. With `en` = 0 and ready packets present, `busy` stays 0. Dropping `en` mid-packet still lets that packet finish.
- Asynchronous reset: assert `rst_n` low mid-BODY. Required: `tx_empty` = 1 and `src_rd_en` = 0 immediately, without waiting for a clock edge, and all flags and counters cleared.
